// File: rtl/hex_sum_lcd.sv
// Two-operand hex adder that drives an HD44780-style LCD over a 4-bit, write-only bus.
// The registered sum is shown as WIDTH/4+1 uppercase hex digits starting at DDRAM address 0x00.
module hex_sum_lcd #(
  parameter int WIDTH    = 8,
  parameter int PWR_CYC  = 750000,
  parameter int E_CYC    = 12,
  parameter int GAP_CYC  = 2000,
  parameter int LONG_CYC = 82000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] no,
  input  logic             push1,
  input  logic             push2,
  output logic             ledpin,
  output logic             busy,
  output logic             sf_e,
  output logic             lcd_e,
  output logic             lcd_rs,
  output logic             lcd_rw,
  output logic [3:0]       lcd_d
);
  localparam int D     = WIDTH / 4 + 1;
  localparam int CMAX0 = (PWR_CYC > LONG_CYC) ? PWR_CYC : LONG_CYC;
  localparam int CMAX1 = (CMAX0 > GAP_CYC) ? CMAX0 : GAP_CYC;
  localparam int CMAX  = (CMAX1 > E_CYC) ? CMAX1 : E_CYC;
  localparam int CW    = $clog2(CMAX + 1);
  localparam int IW    = 5;

  localparam logic [CW-1:0] C_PWR  = CW'(PWR_CYC - 1);
  localparam logic [CW-1:0] C_E    = CW'(E_CYC - 1);
  localparam logic [CW-1:0] C_GAP  = CW'(GAP_CYC - 1);
  localparam logic [CW-1:0] C_LONG = CW'(LONG_CYC - 1);
  localparam logic [IW-1:0] L_INIT = IW'(11);
  localparam logic [IW-1:0] L_ADDR = IW'(1);
  localparam logic [IW-1:0] L_DATA = IW'(2 * D - 1);

  typedef enum logic [2:0] {S_PWR_WAIT, S_INIT, S_IDLE, S_ADDR, S_DATA} state_t;
  typedef enum logic [1:0] {PH_SETUP, PH_EHI, PH_WAIT} phase_t;

  logic [WIDTH-1:0] r_a, r_b;
  logic [WIDTH:0]   r_sum, r_snap, w_snap_next, w_sum;
  logic             r_pend, w_pend_next, w_sum_chg;
  state_t           r_state, w_state_next;
  phase_t           r_ph, w_ph_next;
  logic [CW-1:0]    r_cnt, w_cnt_next, w_cnt_inc, w_wait_max;
  logic [IW-1:0]    r_idx, w_idx_next;
  logic             w_last, w_long;
  logic             r_lcd_e, r_lcd_rs, w_e_next, w_rs_next;
  logic [3:0]       r_lcd_d, w_d_next;

  // Nibble to place on the bus for a given sequencer position.
  function automatic logic [3:0] f_nib(input state_t s, input logic [IW-1:0] idx,
                                       input logic [WIDTH:0] snap);
    logic [4*D-1:0] pad;
    logic [3:0]     dig;
    logic [7:0]     chr;
    int             k;
    pad = '0;
    pad[WIDTH:0] = snap;
    dig = '0;
    k = D - 1 - int'(idx[IW-1:1]);
    for (int j = 0; j < D; j++) begin
      if (j == k) dig = pad[4*j +: 4];
    end
    chr = (dig < 4'd10) ? (8'h30 + {4'h0, dig}) : (8'h37 + {4'h0, dig});
    f_nib = 4'h0;
    case (s)
      S_INIT: begin
        case (idx)
          5'd0, 5'd1, 5'd2: f_nib = 4'h3;
          5'd3, 5'd4:       f_nib = 4'h2;
          5'd5:             f_nib = 4'h8;
          5'd7:             f_nib = 4'h6;
          5'd9:             f_nib = 4'hC;
          5'd11:            f_nib = 4'h1;
          default:          f_nib = 4'h0;
        endcase
      end
      S_ADDR:  f_nib = idx[0] ? 4'h0 : 4'h8;
      S_DATA:  f_nib = idx[0] ? chr[3:0] : chr[7:4];
      default: f_nib = 4'h0;
    endcase
  endfunction

  assign w_sum     = {1'b0, r_a} + {1'b0, r_b};
  assign w_sum_chg = (w_sum != r_sum);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_sum <= '0;
    end else begin
      if (push1)      r_a <= no;
      else if (push2) r_b <= no;
      r_sum <= w_sum;
    end
  end

  assign w_cnt_inc  = (r_cnt == '1) ? r_cnt : r_cnt + CW'(1);
  assign w_long     = (r_state == S_INIT) && ((r_idx < IW'(4)) || (r_idx >= IW'(10)));
  assign w_wait_max = w_long ? C_LONG : C_GAP;
  assign w_last     = (r_state == S_INIT) ? (r_idx == L_INIT) :
                      (r_state == S_ADDR) ? (r_idx == L_ADDR) : (r_idx == L_DATA);

  always_comb begin
    w_state_next = r_state;
    w_ph_next    = r_ph;
    w_cnt_next   = r_cnt;
    w_idx_next   = r_idx;
    w_snap_next  = r_snap;
    w_pend_next  = r_pend | w_sum_chg;
    case (r_state)
      S_PWR_WAIT: begin
        if (r_cnt >= C_PWR) begin
          w_state_next = S_INIT;
          w_ph_next    = PH_SETUP;
          w_cnt_next   = '0;
          w_idx_next   = '0;
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end
      S_IDLE: begin
        // A change landing on this very edge keeps pending set for a follow-up pass.
        if (r_pend) begin
          w_snap_next  = r_sum;
          w_pend_next  = w_sum_chg;
          w_state_next = S_ADDR;
          w_ph_next    = PH_SETUP;
          w_cnt_next   = '0;
          w_idx_next   = '0;
        end
      end
      default: begin
        case (r_ph)
          PH_SETUP: begin
            w_ph_next  = PH_EHI;
            w_cnt_next = '0;
          end
          PH_EHI: begin
            if (r_cnt >= C_E) begin
              w_ph_next  = PH_WAIT;
              w_cnt_next = '0;
            end else begin
              w_cnt_next = w_cnt_inc;
            end
          end
          default: begin
            if (r_cnt >= w_wait_max) begin
              w_ph_next  = PH_SETUP;
              w_cnt_next = '0;
              if (w_last) begin
                w_idx_next = '0;
                case (r_state)
                  S_INIT: begin
                    w_state_next = S_IDLE;
                    w_pend_next  = 1'b1;
                  end
                  S_ADDR:  w_state_next = S_DATA;
                  default: w_state_next = S_IDLE;
                endcase
              end else begin
                w_idx_next = r_idx + IW'(1);
              end
            end else begin
              w_cnt_next = w_cnt_inc;
            end
          end
        endcase
      end
    endcase
    w_e_next  = (w_ph_next == PH_EHI);
    w_rs_next = (w_state_next == S_DATA);
    w_d_next  = f_nib(w_state_next, w_idx_next, w_snap_next);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_PWR_WAIT;
      r_ph     <= PH_SETUP;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_snap   <= '0;
      r_pend   <= 1'b0;
      r_lcd_e  <= 1'b0;
      r_lcd_rs <= 1'b0;
      r_lcd_d  <= 4'h0;
    end else begin
      r_state  <= w_state_next;
      r_ph     <= w_ph_next;
      r_cnt    <= w_cnt_next;
      r_idx    <= w_idx_next;
      r_snap   <= w_snap_next;
      r_pend   <= w_pend_next;
      r_lcd_e  <= w_e_next;
      r_lcd_rs <= w_rs_next;
      r_lcd_d  <= w_d_next;
    end
  end

  assign ledpin = r_sum[WIDTH];
  assign busy   = !((r_state == S_IDLE) && !r_pend);
  assign sf_e   = 1'b1;
  assign lcd_rw = 1'b0;
  assign lcd_e  = r_lcd_e;
  assign lcd_rs = r_lcd_rs;
  assign lcd_d  = r_lcd_d;
endmodule
